// File: rtl/axil_pkg.sv
// axil_pkg: shared types for the AXI4-Lite initiator.
// Holds the FSM state enum, the AXI response codes and the latched command
// record. The record is sized for the widest supported bus; the initiator
// zero-extends into it and slices back out at its configured widths.
package axil_pkg;

  localparam int AXIL_MAX_ADDRESS_WIDTH = 32;
  localparam int AXIL_MAX_DATA_WIDTH    = 64;
  localparam int AXIL_MAX_STROBE_WIDTH  = AXIL_MAX_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    WRITE          = 3'd1,
    WRITE_RESPONSE = 3'd2,
    READ_ADDRESS   = 3'd3,
    READ_DATA      = 3'd4,
    RESPOND        = 3'd5
  } axil_master_state_t;

  localparam logic [1:0] AXIL_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXIL_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXIL_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR  = 2'b11;
  // Timeout shares the DECERR encoding so callers see it as a hard failure.
  localparam logic [1:0] AXIL_RESP_TIMEOUT = 2'b11;

  typedef struct packed {
    logic                               write;
    logic [AXIL_MAX_ADDRESS_WIDTH-1:0]  address;
    logic [AXIL_MAX_DATA_WIDTH-1:0]     data;
    logic [AXIL_MAX_STROBE_WIDTH-1:0]   strobe;
  } axil_request_t;

  // States in which the initiator is waiting on the responder.
  function automatic logic is_waiting_state(input axil_master_state_t state);
    return (state == WRITE) || (state == WRITE_RESPONSE) ||
           (state == READ_ADDRESS) || (state == READ_DATA);
  endfunction

endpackage

// File: rtl/axil_master_if.sv
// axil_master_if: command/response port plus AXI4-Lite master bus of the
// initiator. The master modport is the initiator's view; the slave modport
// is the combined view of the application and the AXI responder.
interface axil_master_if #(
  parameter int AXIL_ADDRESS_WIDTH = 11,
  parameter int AXIL_DATA_WIDTH    = 32
);

  localparam int AXIL_STROBE_WIDTH = AXIL_DATA_WIDTH / 8;

  logic                          request_valid;
  logic                          request_ready;
  logic                          request_write;
  logic [AXIL_ADDRESS_WIDTH-1:0] request_address;
  logic [AXIL_DATA_WIDTH-1:0]    request_write_data;
  logic [AXIL_STROBE_WIDTH-1:0]  request_write_strobe;

  logic                          response_valid;
  logic                          response_ready;
  logic [AXIL_DATA_WIDTH-1:0]    response_read_data;
  logic [1:0]                    response_status;

  logic [AXIL_ADDRESS_WIDTH-1:0] AXIL_awaddr;
  logic [2:0]                    AXIL_awprot;
  logic                          AXIL_awvalid;
  logic                          AXIL_awready;
  logic [AXIL_DATA_WIDTH-1:0]    AXIL_wdata;
  logic [AXIL_STROBE_WIDTH-1:0]  AXIL_wstrb;
  logic                          AXIL_wvalid;
  logic                          AXIL_wready;
  logic [1:0]                    AXIL_bresp;
  logic                          AXIL_bvalid;
  logic                          AXIL_bready;
  logic [AXIL_ADDRESS_WIDTH-1:0] AXIL_araddr;
  logic [2:0]                    AXIL_arprot;
  logic                          AXIL_arvalid;
  logic                          AXIL_arready;
  logic [AXIL_DATA_WIDTH-1:0]    AXIL_rdata;
  logic [1:0]                    AXIL_rresp;
  logic                          AXIL_rvalid;
  logic                          AXIL_rready;

  modport master (
    input  request_valid, request_write, request_address,
           request_write_data, request_write_strobe, response_ready,
    output request_ready, response_valid, response_read_data, response_status,
    output AXIL_awaddr, AXIL_awprot, AXIL_awvalid,
    input  AXIL_awready,
    output AXIL_wdata, AXIL_wstrb, AXIL_wvalid,
    input  AXIL_wready,
    input  AXIL_bresp, AXIL_bvalid,
    output AXIL_bready,
    output AXIL_araddr, AXIL_arprot, AXIL_arvalid,
    input  AXIL_arready,
    input  AXIL_rdata, AXIL_rresp, AXIL_rvalid,
    output AXIL_rready
  );

  modport slave (
    output request_valid, request_write, request_address,
           request_write_data, request_write_strobe, response_ready,
    input  request_ready, response_valid, response_read_data, response_status,
    input  AXIL_awaddr, AXIL_awprot, AXIL_awvalid,
    output AXIL_awready,
    input  AXIL_wdata, AXIL_wstrb, AXIL_wvalid,
    output AXIL_wready,
    output AXIL_bresp, AXIL_bvalid,
    input  AXIL_bready,
    input  AXIL_araddr, AXIL_arprot, AXIL_arvalid,
    output AXIL_arready,
    output AXIL_rdata, AXIL_rresp, AXIL_rvalid,
    input  AXIL_rready
  );

endinterface

// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite initiator.
// A command accepted on the request port becomes one AXI4-Lite write or read;
// the result is presented on the response port until consumed. Every AXI
// output comes from a register, so the bus never sees request_* directly.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN to bound each channel wait
// to TIMEOUT_CYCLES; the stuck transaction then completes with status 2'b11.
module axil_master
  import axil_pkg::*;
#(
  parameter int AXIL_ADDRESS_WIDTH = 11,
  parameter int AXIL_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input logic         clock,
  input logic         reset_n,
  axil_master_if.master bus
);

  localparam int AXIL_STROBE_WIDTH = AXIL_DATA_WIDTH / 8;

  if ((AXIL_DATA_WIDTH != 32 && AXIL_DATA_WIDTH != 64) ||
      (AXIL_ADDRESS_WIDTH < 1) || (AXIL_ADDRESS_WIDTH > AXIL_MAX_ADDRESS_WIDTH) ||
      (TIMEOUT_CYCLES < 2)) begin : g_bad_parameters
    $error("axil_master: unsupported parameter combination");
  end

  axil_master_state_t state_q, state_d;
  axil_request_t      request_q, request_d;

  logic request_ready_q, request_ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic response_valid_q, response_valid_d;
  logic [AXIL_DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [1:0] status_q, status_d;

  logic aw_handshake;
  logic w_handshake;
  logic timeout_hit;

  assign aw_handshake = awvalid_q && bus.AXIL_awready;
  assign w_handshake  = wvalid_q && bus.AXIL_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TIMEOUT_COUNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_q, timeout_count_d;

  // Watchdog fires on the last allowed cycle of any responder wait.
  always_comb begin
    timeout_hit = is_waiting_state(state_q) &&
                  (timeout_count_q == TIMEOUT_COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
    timeout_count_d = timeout_count_q;
    if (state_d != state_q) begin
      timeout_count_d = '0;
    end else if (is_waiting_state(state_q)) begin
      timeout_count_d = timeout_count_q + TIMEOUT_COUNT_WIDTH'(1);
    end
  end

  // Watchdog counter restarts on every state change.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timeout_count_q <= '0;
    end else begin
      timeout_count_q <= timeout_count_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; everything holds unless a handshake moves it.
  always_comb begin
    state_d          = state_q;
    request_d        = request_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    bready_d         = bready_q;
    arvalid_d        = arvalid_q;
    rready_d         = rready_q;
    response_valid_d = response_valid_q;
    read_data_d      = read_data_q;
    status_d         = status_q;

    case (state_q)
      IDLE: begin
        if (bus.request_valid && request_ready_q) begin
          request_d.write   = bus.request_write;
          request_d.address = AXIL_MAX_ADDRESS_WIDTH'(bus.request_address);
          request_d.data    = AXIL_MAX_DATA_WIDTH'(bus.request_write_data);
          request_d.strobe  = AXIL_MAX_STROBE_WIDTH'(bus.request_write_strobe);
          if (bus.request_write) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = READ_ADDRESS;
            arvalid_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (aw_handshake) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_handshake) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WRITE_RESPONSE;
          bready_d = 1'b1;
        end
      end

      WRITE_RESPONSE: begin
        if (bus.AXIL_bvalid && bready_q) begin
          status_d         = bus.AXIL_bresp;
          read_data_d      = '0;
          bready_d         = 1'b0;
          response_valid_d = 1'b1;
          state_d          = RESPOND;
        end
      end

      READ_ADDRESS: begin
        if (arvalid_q && bus.AXIL_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = READ_DATA;
        end
      end

      READ_DATA: begin
        if (bus.AXIL_rvalid && rready_q) begin
          read_data_d      = bus.AXIL_rdata;
          status_d         = bus.AXIL_rresp;
          rready_d         = 1'b0;
          response_valid_d = 1'b1;
          state_d          = RESPOND;
        end
      end

      RESPOND: begin
        if (response_valid_q && bus.response_ready) begin
          response_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A stuck responder is abandoned: bus handshakes drop and a timeout is reported.
    if (timeout_hit) begin
      awvalid_d        = 1'b0;
      wvalid_d         = 1'b0;
      bready_d         = 1'b0;
      arvalid_d        = 1'b0;
      rready_d         = 1'b0;
      read_data_d      = '0;
      status_d         = AXIL_RESP_TIMEOUT;
      response_valid_d = 1'b1;
      state_d          = RESPOND;
    end

    request_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      request_q        <= '0;
      request_ready_q  <= 1'b0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      aw_done_q        <= 1'b0;
      w_done_q         <= 1'b0;
      bready_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      response_valid_q <= 1'b0;
      read_data_q      <= '0;
      status_q         <= AXIL_RESP_OKAY;
    end else begin
      state_q          <= state_d;
      request_q        <= request_d;
      request_ready_q  <= request_ready_d;
      awvalid_q        <= awvalid_d;
      wvalid_q         <= wvalid_d;
      aw_done_q        <= aw_done_d;
      w_done_q         <= w_done_d;
      bready_q         <= bready_d;
      arvalid_q        <= arvalid_d;
      rready_q         <= rready_d;
      response_valid_q <= response_valid_d;
      read_data_q      <= read_data_d;
      status_q         <= status_d;
    end
  end

  // The record is sized for the widest bus; fold its padding so no bit dangles.
  logic unused_request_bits;
  assign unused_request_bits = ^request_q;

  assign bus.request_ready      = request_ready_q;
  assign bus.response_valid     = response_valid_q;
  assign bus.response_read_data = read_data_q;
  assign bus.response_status    = status_q;

  assign bus.AXIL_awaddr  = request_q.address[AXIL_ADDRESS_WIDTH-1:0];
  assign bus.AXIL_awprot  = 3'b000;
  assign bus.AXIL_awvalid = awvalid_q;
  assign bus.AXIL_wdata   = request_q.data[AXIL_DATA_WIDTH-1:0];
  assign bus.AXIL_wstrb   = request_q.strobe[AXIL_STROBE_WIDTH-1:0];
  assign bus.AXIL_wvalid  = wvalid_q;
  assign bus.AXIL_bready  = bready_q;
  assign bus.AXIL_araddr  = request_q.address[AXIL_ADDRESS_WIDTH-1:0];
  assign bus.AXIL_arprot  = 3'b000;
  assign bus.AXIL_arvalid = arvalid_q;
  assign bus.AXIL_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: directed bench for axil_master.
// The bench plays both the application (request/response port) and the AXI
// responder, driving inputs 1ns after each rising edge and checking outputs
// at the same point. Cycle 0 is the cycle in which the command is accepted.
module tb_axil_master;

  localparam int AW = 11;
  localparam int DW = 32;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   b_beats = 0;

  axil_master_if #(.AXIL_ADDRESS_WIDTH(AW), .AXIL_DATA_WIDTH(DW)) bus ();

  axil_master #(
    .AXIL_ADDRESS_WIDTH(AW),
    .AXIL_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  // {awvalid, wvalid, bready, arvalid, rready, response_valid, request_ready}
  logic [6:0] ctl;
  assign ctl = {bus.AXIL_awvalid, bus.AXIL_wvalid, bus.AXIL_bready, bus.AXIL_arvalid,
                bus.AXIL_rready, bus.response_valid, bus.request_ready};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count accepted B beats, sampled mid-cycle when both sides are stable.
  always @(negedge clock) begin
    if (bus.AXIL_bvalid && bus.AXIL_bready) b_beats++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_request_ready();
    for (int i = 0; i < 40 && bus.request_ready !== 1'b1; i++) step();
    checks++;
    if (bus.request_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_request_ready: got %b required 1", bus.request_ready);
    end
  endtask

  // Offer one command in cycle 0; returns positioned in cycle 1.
  task automatic offer(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    bus.request_valid        = 1'b1;
    bus.request_write        = wr;
    bus.request_address      = addr;
    bus.request_write_data   = data;
    bus.request_write_strobe = strb;
    step();
    bus.request_valid        = 1'b0;
    bus.request_write_data   = '0;
  endtask

  task automatic zero_wait_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [DW/8-1:0] strb);
    wait_request_ready();
    offer(1'b1, addr, data, strb);
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("[TB] FAIL write_c1_ctl: got %b required 1100000", ctl);
    end
    checks++;
    if ({bus.AXIL_awaddr, bus.AXIL_wdata, bus.AXIL_wstrb, bus.AXIL_awprot} !== {addr, data, strb, 3'b000}) begin
      errors++;
      $display("[TB] FAIL write_c1_bus: got awaddr=%h wdata=%h wstrb=%h awprot=%b required %h %h %h 000",
               bus.AXIL_awaddr, bus.AXIL_wdata, bus.AXIL_wstrb, bus.AXIL_awprot, addr, data, strb);
    end
    step();
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("[TB] FAIL write_c2_ctl: got %b required 0010000", ctl);
    end
    bus.AXIL_bvalid = 1'b1;
    bus.AXIL_bresp  = 2'b00;
    step();
    bus.AXIL_bvalid = 1'b0;
    checks++;
    if ({ctl, bus.response_status, bus.response_read_data} !== {7'b0000010, 2'b00, 32'h0}) begin
      errors++;
      $display("[TB] FAIL write_c3_response: got ctl=%b status=%b data=%h required 0000010 00 00000000",
               ctl, bus.response_status, bus.response_read_data);
    end
    bus.response_ready = 1'b1;
    step();
    bus.response_ready = 1'b0;
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL write_c4_ctl: got %b required 0000001", ctl);
    end
  endtask

  task automatic zero_wait_read(input logic [AW-1:0] addr, input logic [DW-1:0] shell_data);
    wait_request_ready();
    offer(1'b0, addr, 32'h0, 4'h0);
    checks++;
    if ({ctl, bus.AXIL_araddr, bus.AXIL_arprot} !== {7'b0001000, addr, 3'b000}) begin
      errors++;
      $display("[TB] FAIL read_c1: got ctl=%b araddr=%h arprot=%b required 0001000 %h 000",
               ctl, bus.AXIL_araddr, bus.AXIL_arprot, addr);
    end
    step();
    checks++;
    if (ctl !== 7'b0000100) begin
      errors++; $display("[TB] FAIL read_c2_ctl: got %b required 0000100", ctl);
    end
    bus.AXIL_rvalid = 1'b1;
    bus.AXIL_rdata  = shell_data;
    bus.AXIL_rresp  = 2'b00;
    step();
    bus.AXIL_rvalid = 1'b0;
    bus.AXIL_rdata  = '0;
    checks++;
    if ({ctl, bus.response_status, bus.response_read_data} !== {7'b0000010, 2'b00, shell_data}) begin
      errors++;
      $display("[TB] FAIL read_c3_response: got ctl=%b status=%b data=%h required 0000010 00 %h",
               ctl, bus.response_status, bus.response_read_data, shell_data);
    end
    bus.response_ready = 1'b1;
    step();
    bus.response_ready = 1'b0;
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL read_c4_ctl: got %b required 0000001", ctl);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step(); step();
    checks++;
    if ({ctl, bus.response_status, bus.response_read_data} !== 41'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got ctl=%b status=%b data=%h required all zero",
               ctl, bus.response_status, bus.response_read_data);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL reset_release: got %b required 0000001", ctl);
    end
  endtask

  task automatic test_write_zero_wait();
    zero_wait_write(11'h404, 32'hDEAD_BEEF, 4'hF);
  endtask

  task automatic test_read_shell();
    zero_wait_read(11'h404, 32'hDEAD_BEEF);
  endtask

  task automatic test_write_aw_first();
    int beats_before;
    beats_before = b_beats;
    bus.AXIL_wready = 1'b0;
    wait_request_ready();
    offer(1'b1, 11'h0A8, 32'h0BAD_F00D, 4'h3);
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("[TB] FAIL awfirst_c1: got %b required 1100000", ctl);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if ({ctl, bus.AXIL_wdata, bus.AXIL_wstrb} !== {7'b0100000, 32'h0BAD_F00D, 4'h3}) begin
        errors++;
        $display("[TB] FAIL awfirst_hold_c%0d: got ctl=%b wdata=%h wstrb=%h required 0100000 0badf00d 3",
                 c, ctl, bus.AXIL_wdata, bus.AXIL_wstrb);
      end
    end
    bus.AXIL_wready = 1'b1;
    step();
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("[TB] FAIL awfirst_c5: got %b required 0010000", ctl);
    end
    bus.AXIL_bvalid = 1'b1;
    bus.AXIL_bresp  = 2'b00;
    step();
    bus.AXIL_bvalid = 1'b0;
    checks++;
    if (ctl !== 7'b0000010) begin
      errors++; $display("[TB] FAIL awfirst_c6: got %b required 0000010", ctl);
    end
    bus.response_ready = 1'b1;
    step();
    bus.response_ready = 1'b0;
    step();
    checks++;
    if (b_beats - beats_before !== 1) begin
      errors++; $display("[TB] FAIL awfirst_b_beats: got %0d required 1", b_beats - beats_before);
    end
  endtask

  task automatic test_read_error_stall();
    bus.AXIL_arready = 1'b0;
    wait_request_ready();
    offer(1'b0, 11'h010, 32'h0, 4'h0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus.AXIL_arready = 1'b1;
      checks++;
      if ({ctl, bus.AXIL_araddr} !== {7'b0001000, 11'h010}) begin
        errors++;
        $display("[TB] FAIL rderr_ar_hold_c%0d: got ctl=%b araddr=%h required 0001000 010", c, ctl, bus.AXIL_araddr);
      end
      step();
    end
    checks++;
    if (ctl !== 7'b0000100) begin
      errors++; $display("[TB] FAIL rderr_c4: got %b required 0000100", ctl);
    end
    bus.AXIL_rvalid = 1'b1;
    bus.AXIL_rdata  = 32'h1234_5678;
    bus.AXIL_rresp  = 2'b10;
    step();
    bus.AXIL_rvalid = 1'b0;
    bus.AXIL_rdata  = '0;
    bus.AXIL_rresp  = 2'b00;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({ctl, bus.response_status, bus.response_read_data} !== {7'b0000010, 2'b10, 32'h1234_5678}) begin
        errors++;
        $display("[TB] FAIL rderr_stall_%0d: got ctl=%b status=%b data=%h required 0000010 10 12345678",
                 c, ctl, bus.response_status, bus.response_read_data);
      end
      step();
    end
    bus.response_ready = 1'b1;
    step();
    bus.response_ready = 1'b0;
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL rderr_release: got %b required 0000001", ctl);
    end
  endtask

  task automatic test_reset_mid_write();
    wait_request_ready();
    offer(1'b1, 11'h100, 32'hCAFE_0001, 4'hF);
    step();
    checks++;
    if (ctl !== 7'b0010000) begin
      errors++; $display("[TB] FAIL midrst_in_wresp: got %b required 0010000", ctl);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if ({ctl, bus.response_status} !== 9'h0) begin
      errors++; $display("[TB] FAIL midrst_cleared: got ctl=%b status=%b required 0000000 00", ctl, bus.response_status);
    end
    step();
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL midrst_no_response: got %b required 0000001", ctl);
    end
    zero_wait_read(11'h404, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    zero_wait_read(11'h7FC, 32'hA5A5_5A5A);
    zero_wait_write(11'h008, 32'h0000_00FF, 4'h1);
    zero_wait_read(11'h000, 32'hFFFF_FFFF);
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bus.AXIL_arready = 1'b0;
    wait_request_ready();
    offer(1'b0, 11'h020, 32'h0, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (ctl !== 7'b0001000) begin
        errors++; $display("[TB] FAIL timeout_wait_c%0d: got %b required 0001000", c, ctl);
      end
      step();
    end
    checks++;
    if ({ctl, bus.response_status, bus.response_read_data} !== {7'b0000010, 2'b11, 32'h0}) begin
      errors++;
      $display("[TB] FAIL timeout_response: got ctl=%b status=%b data=%h required 0000010 11 00000000",
               ctl, bus.response_status, bus.response_read_data);
    end
    bus.response_ready = 1'b1;
    step();
    bus.response_ready = 1'b0;
    bus.AXIL_arready   = 1'b1;
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++; $display("[TB] FAIL timeout_release: got %b required 0000001", ctl);
    end
  endtask
`endif

  initial begin
    reset_n                  = 1'b0;
    bus.request_valid        = 1'b0;
    bus.request_write        = 1'b0;
    bus.request_address      = '0;
    bus.request_write_data   = '0;
    bus.request_write_strobe = '0;
    bus.response_ready       = 1'b0;
    bus.AXIL_awready         = 1'b1;
    bus.AXIL_wready          = 1'b1;
    bus.AXIL_bvalid          = 1'b0;
    bus.AXIL_bresp           = 2'b00;
    bus.AXIL_arready         = 1'b1;
    bus.AXIL_rvalid          = 1'b0;
    bus.AXIL_rdata           = '0;
    bus.AXIL_rresp           = 2'b00;

    test_reset();
    test_write_zero_wait();
    test_read_shell();
    test_write_aw_first();
    test_read_error_stall();
    test_reset_mid_write();
    test_back_to_back();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
